// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period, high time and low time of a divided clock
// (sig_in) in clk_in cycles over NUM_PERIODS consecutive periods. It flags any
// later period that differs from the first (mismatch). It also flags a run that
// ended because no rising edge arrived in time (timeout).
module clk_period_meter #(
  parameter int CNT_W       = 16,
  parameter int NUM_PERIODS = 8,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             start,
  input  logic             sig_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] low_time,
  output logic             mismatch,
  output logic             timeout
);

  localparam int IDX_W = (NUM_PERIODS > 1) ? $clog2(NUM_PERIODS) : 1;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PERIODS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_MEASURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic             w_rise;
  logic             w_level;

  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] r_hi_cnt;
  logic [IDX_W-1:0] r_idx;

  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high_time;
  logic [CNT_W-1:0] r_low_time;
  logic             r_mismatch;
  logic             r_timeout;

  logic             w_arm_entry;
  logic             w_close;
  logic             w_to_hit;

  assign w_rise  = r_s2 & ~r_s3;
  assign w_level = r_s2;

  // Synchronize sig_in into clk_in and keep one extra stage for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the clock edge, which makes the shift chain work.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic, status outputs and datapath control strobes.
  // NOTE: every signal written here gets a default first; a branch that skipped
  // one would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_arm_entry  = 1'b0;
    w_close      = 1'b0;
    w_to_hit     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_ARM;
          w_arm_entry  = 1'b1;
        end
      end
      S_ARM: begin
        busy = 1'b1;
        if (w_rise) begin
          w_state_next = S_MEASURE;
        end else if (r_timer == TO_LAST) begin
          w_state_next = S_DONE;
          w_to_hit     = 1'b1;
        end
      end
      S_MEASURE: begin
        busy = 1'b1;
        if (w_rise) begin
          w_close = 1'b1;
          if (r_idx == IDX_LAST) begin
            w_state_next = S_DONE;
          end
        end else if (r_per_cnt == TO_LAST) begin
          w_state_next = S_DONE;
          w_to_hit     = 1'b1;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Wait timer and per-period counters. The rising-edge cycle itself counts as
  // the first (high) cycle of the new period, hence the reload value of 1.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_timer   <= '0;
      r_per_cnt <= '0;
      r_hi_cnt  <= '0;
      r_idx     <= '0;
    end else begin
      if (w_arm_entry) begin
        r_timer <= '0;
      end else if (r_state == S_ARM) begin
        r_timer <= r_timer + CNT_W'(1);
      end

      if (r_state == S_ARM && w_rise) begin
        r_per_cnt <= CNT_W'(1);
        r_hi_cnt  <= CNT_W'(1);
        r_idx     <= '0;
      end else if (r_state == S_MEASURE) begin
        if (w_close) begin
          r_per_cnt <= CNT_W'(1);
          r_hi_cnt  <= CNT_W'(1);
          r_idx     <= r_idx + IDX_W'(1);
        end else begin
          r_per_cnt <= r_per_cnt + CNT_W'(1);
          r_hi_cnt  <= r_hi_cnt + CNT_W'(w_level);
        end
      end
    end
  end

  // Results: the first closed period is captured and later ones are compared
  // against it. Results hold until the next accepted start clears them.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_period    <= '0;
      r_high_time <= '0;
      r_low_time  <= '0;
      r_mismatch  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      if (w_arm_entry) begin
        r_period    <= '0;
        r_high_time <= '0;
        r_low_time  <= '0;
        r_mismatch  <= 1'b0;
        r_timeout   <= 1'b0;
      end else begin
        if (w_close) begin
          if (r_idx == '0) begin
            r_period    <= r_per_cnt;
            r_high_time <= r_hi_cnt;
            r_low_time  <= r_per_cnt - r_hi_cnt;
          end else if (r_per_cnt != r_period || r_hi_cnt != r_high_time) begin
            r_mismatch <= 1'b1;
          end
        end
        if (w_to_hit) begin
          r_timeout <= 1'b1;
        end
      end
    end
  end

  assign period    = r_period;
  assign high_time = r_high_time;
  assign low_time  = r_low_time;
  assign mismatch  = r_mismatch;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_clk_period_meter.sv
// Testbench for clk_period_meter: directed and random sig_in waveforms, with
// expected results pushed into a scoreboard queue. A monitor pops the queue
// and compares on each done pulse.
module tb_clk_period_meter;

  localparam int CNT_W = 16;
  localparam int NP    = 8;
  localparam int TO    = 1024;

  logic             clk_in = 1'b0;
  logic             rst    = 1'b0;
  logic             start  = 1'b0;
  logic             sig_in = 1'b0;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] low_time;
  logic             mismatch;
  logic             timeout;

  clk_period_meter #(
    .CNT_W      (CNT_W),
    .NUM_PERIODS(NP),
    .TIMEOUT    (TO)
  ) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .start    (start),
    .sig_in   (sig_in),
    .busy     (busy),
    .done     (done),
    .period   (period),
    .high_time(high_time),
    .low_time (low_time),
    .mismatch (mismatch),
    .timeout  (timeout)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int p;
    int h;
    int l;
    bit mis;
    bit to;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done   = 0;
  int   wp[NP];
  int   wh[NP];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk_in) begin
    if (rst && done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("period",    32'(period),    32'(mon_e.p));
        check("high_time", 32'(high_time), 32'(mon_e.h));
        check("low_time",  32'(low_time),  32'(mon_e.l));
        check("mismatch",  32'(mismatch),  32'(mon_e.mis));
        check("timeout",   32'(timeout),   32'(mon_e.to));
        check("busy_at_done", 32'(busy),   32'd0);
      end
    end
  end

  // Reference: the first period defines the results; any later period whose
  // length or high time differs sets mismatch.
  function automatic exp_t model();
    exp_t e;
    e.p   = wp[0];
    e.h   = wh[0];
    e.l   = wp[0] - wh[0];
    e.mis = 1'b0;
    e.to  = 1'b0;
    for (int k = 1; k < NP; k++) begin
      if (wp[k] != wp[0] || wh[k] != wh[0]) e.mis = 1'b1;
    end
    return e;
  endfunction

  // All driver code runs 1 ns after a rising edge.
  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = v;
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk_in);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int c = 0;
    while (n_done < target && c < budget) begin
      @(posedge clk_in);
      #1;
      c++;
    end
    check("done_seen", 32'(n_done >= target), 32'd1);
  endtask

  task automatic uniform(input int p, input int h);
    for (int k = 0; k < NP; k++) begin
      wp[k] = p;
      wh[k] = h;
    end
  endtask

  // Drive NP periods (high first) plus the closing rising edge.
  task automatic run_wave(input int lead, input bit extra_start);
    exp_t e;
    int   target;
    e = model();
    exp_q.push_back(e);
    target = n_done + 1;
    pulse_start();
    hold(1'b0, lead);
    for (int k = 0; k < NP; k++) begin
      if (k == NP / 2) check("busy_mid", 32'(busy), 32'd1);
      if (extra_start && k == NP - 1) begin
        start = 1'b1;
        hold(1'b1, 1);
        start = 1'b0;
        hold(1'b1, wh[k] - 1);
      end else begin
        hold(1'b1, wh[k]);
      end
      hold(1'b0, wp[k] - wh[k]);
    end
    hold(1'b1, 2);
    hold(1'b0, 1);
    wait_done(target, 10);
    hold(1'b0, 5);
    check("hold_period", 32'(period), 32'(e.p));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_t e;
    int   cnt;
    int   snap;

    // Reset state.
    #12;
    check("rst_busy",     32'(busy),      32'd0);
    check("rst_done",     32'(done),      32'd0);
    check("rst_period",   32'(period),    32'd0);
    check("rst_high",     32'(high_time), 32'd0);
    check("rst_low",      32'(low_time),  32'd0);
    check("rst_mismatch", 32'(mismatch),  32'd0);
    check("rst_timeout",  32'(timeout),   32'd0);
    @(posedge clk_in);
    #1 rst = 1'b1;
    hold(1'b0, 4);

    // Directed: div-4, div-5 style, div-28.
    uniform(4, 2);
    run_wave(0, 1'b0);
    uniform(5, 3);
    run_wave(2, 1'b0);
    uniform(28, 14);
    run_wave(3, 1'b0);

    // Stuck-low input: timeout exactly TO cycles after entering ARM.
    e = '{p: 0, h: 0, l: 0, mis: 1'b0, to: 1'b1};
    exp_q.push_back(e);
    snap = n_done;
    pulse_start();
    cnt = 0;
    while (cnt < TO + 20) begin
      @(posedge clk_in);
      cnt++;
      @(negedge clk_in);
      if (done) break;
    end
    check("timeout_latency", 32'(cnt), 32'(TO));
    @(posedge clk_in);
    #1;
    check("timeout_done_count", 32'(n_done), 32'(snap + 1));
    hold(1'b0, 3);

    // Div-4 with one stretched period inside the window.
    uniform(4, 2);
    wp[3] = 6;
    run_wave(1, 1'b0);

    // Start while busy must be ignored: a restart would time out later.
    uniform(4, 2);
    snap = n_done;
    run_wave(2, 1'b1);
    hold(1'b0, TO + 20);
    check("no_restart", 32'(n_done), 32'(snap + 1));

    // Reset mid-MEASURE: no done, all outputs cleared.
    snap = n_done;
    pulse_start();
    hold(1'b0, 1);
    for (int k = 0; k < 3; k++) begin
      hold(1'b1, 2);
      hold(1'b0, 2);
    end
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    sig_in = 1'b0;
    #1;
    check("midrst_busy",     32'(busy),      32'd0);
    check("midrst_done",     32'(done),      32'd0);
    check("midrst_period",   32'(period),    32'd0);
    check("midrst_high",     32'(high_time), 32'd0);
    check("midrst_low",      32'(low_time),  32'd0);
    check("midrst_mismatch", 32'(mismatch),  32'd0);
    @(posedge clk_in);
    @(posedge clk_in);
    #1 rst = 1'b1;
    hold(1'b0, 20);
    check("midrst_no_done", 32'(n_done), 32'(snap));

    // Normal run after reset release.
    uniform(4, 2);
    run_wave(0, 1'b0);

    // Random waveforms, some with one differing period.
    for (int r = 0; r < 12; r++) begin
      int p0;
      int h0;
      int k;
      p0 = $urandom_range(30, 2);
      h0 = $urandom_range(p0 - 1, 1);
      uniform(p0, h0);
      if ($urandom_range(1, 0) == 1) begin
        k     = $urandom_range(NP - 1, 1);
        wp[k] = $urandom_range(30, 2);
        wh[k] = $urandom_range(wp[k] - 1, 1);
      end
      run_wave($urandom_range(6, 0), 1'b0);
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
